// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package regfile_pkg;

    localparam int DEF_XLEN  = 64;
    localparam int DEF_NREGS = 32;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Address width for a register count, never less than one bit.
    function automatic int addr_width(input int nregs);
        return (nregs < 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_wr_select.sv
// Priority match of one query address against all write ports.
// Returns whether any enabled port targets the address and, if so, the data
// of the highest-indexed matching port.
module regfile_wr_select
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int AW     = 5,
    parameter int NWRITE = 1
) (
    input  logic [AW-1:0]          query_addr,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    output logic                   hit,
    output logic [XLEN-1:0]        data
);

    // Ascending scan: a later (higher-index) match overwrites an earlier one.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; blocking '=' is correct inside combinational logic.
        hit  = 1'b0;
        data = '0;
        for (int w = 0; w < NWRITE; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == query_addr)) begin
                hit  = 1'b1;
                data = wr_data[w*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass,
// stall-refresh of held operands, multi-writer priority and a sequenced
// clear engine that zeroes one entry per cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(NREGS)
) (
    input  logic                   clk,
    input  logic                   reset_in,
    input  logic                   stall_in,
    input  logic [NREAD*AW-1:0]    rs_in,
    output logic [NREAD*XLEN-1:0]  rs_value_out,
    input  logic [NWRITE*AW-1:0]   rd_in,
    input  logic [NWRITE-1:0]      rd_write_in,
    input  logic [NWRITE*XLEN-1:0] rd_value_in,
    input  logic                   clear_in,
    output logic                   busy_out
);

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            busy;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic [NWRITE-1:0] wr_eff;

    logic            upd_hit  [NREGS];
    logic [XLEN-1:0] upd_data [NREGS];

    logic [AW-1:0]   qaddr    [NREAD];
    logic            byp_hit  [NREAD];
    logic [XLEN-1:0] byp_data [NREAD];
    logic [AW-1:0]   raddr_q  [NREAD];
    logic [AW-1:0]   raddr_d  [NREAD];
    logic [XLEN-1:0] rval_q   [NREAD];
    logic [XLEN-1:0] rval_d   [NREAD];

    assign busy     = (state_q == RF_CLEAR);
    assign busy_out = busy;

    // A write port commits only when idle and not aimed at a hardwired x0.
    always_comb begin
        for (int w = 0; w < NWRITE; w++) begin
            wr_eff[w] = rd_write_in[w] && !busy &&
                        !((ZERO_REG != 0) && (rd_in[w*AW +: AW] == '0));
        end
    end

    // Clear sequencer next state: start on clear_in, walk idx to NREGS-1, exit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RF_IDLE: begin
                if (clear_in) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            RF_CLEAR: begin
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Clear sequencer state and index registers.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every flop
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // One priority matcher per entry decides which port (if any) updates it.
    for (genvar g = 0; g < NREGS; g++) begin : g_upd
        regfile_wr_select #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWRITE (NWRITE)
        ) u_upd (
            .query_addr (AW'(g)),
            .wr_en      (wr_eff),
            .wr_addr    (rd_in),
            .wr_data    (rd_value_in),
            .hit        (upd_hit[g]),
            .data       (upd_data[g])
        );
    end

    // Next array contents: clear engine zeroes entry idx, otherwise winning write.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (busy && (idx_q == AW'(i))) begin
                regs_d[i] = '0;
            end else if (upd_hit[i]) begin
                regs_d[i] = upd_data[i];
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Register array storage.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            // NOTE: every entry is reset deliberately, so this array maps to
            // flops rather than a RAM macro without a reset pin.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read address per port: live rs_in normally, latched address while stalled.
    always_comb begin
        for (int r = 0; r < NREAD; r++) begin
            qaddr[r]   = stall_in ? raddr_q[r] : rs_in[r*AW +: AW];
            raddr_d[r] = qaddr[r];
        end
    end

    // Bypass matchers share the same priority rule as the array update.
    for (genvar r = 0; r < NREAD; r++) begin : g_byp
        regfile_wr_select #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWRITE (NWRITE)
        ) u_byp (
            .query_addr (qaddr[r]),
            .wr_en      (wr_eff),
            .wr_addr    (rd_in),
            .wr_data    (rd_value_in),
            .hit        (byp_hit[r]),
            .data       (byp_data[r])
        );
    end

    // Next read data: fresh read, or hold with refresh from a same-address write/clear.
    always_comb begin
        for (int r = 0; r < NREAD; r++) begin
            if (stall_in) begin
                rval_d[r] = rval_q[r];
                if (BYPASS != 0) begin
                    if (busy && (qaddr[r] == idx_q)) begin
                        rval_d[r] = '0;
                    end else if (byp_hit[r]) begin
                        rval_d[r] = byp_data[r];
                    end
                end
            end else if ((ZERO_REG != 0) && (qaddr[r] == '0)) begin
                rval_d[r] = '0;
            end else if ((BYPASS != 0) && busy && (qaddr[r] == idx_q)) begin
                rval_d[r] = '0;
            end else if ((BYPASS != 0) && byp_hit[r]) begin
                rval_d[r] = byp_data[r];
            end else begin
                rval_d[r] = regs_q[qaddr[r]];
            end
        end
    end

    // Registered read outputs and the per-port address held across stalls.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            for (int r = 0; r < NREAD; r++) begin
                raddr_q[r] <= '0;
                rval_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NREAD; r++) begin
                raddr_q[r] <= raddr_d[r];
                rval_q[r]  <= rval_d[r];
            end
        end
    end

    // Pack the per-port read registers onto the output bus.
    always_comb begin
        for (int r = 0; r < NREAD; r++) begin
            rs_value_out[r*XLEN +: XLEN] = rval_q[r];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances share stimulus, one with
// bypass enabled and one without, both with two read and two write ports.
module tb_regfile_mp;

    localparam int XLEN   = 64;
    localparam int NREGS  = 32;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   reset_in;
    logic                   stall_in;
    logic                   clear_in;
    logic [NREAD*AW-1:0]    rs_in;
    logic [NWRITE*AW-1:0]   rd_in;
    logic [NWRITE-1:0]      rd_write_in;
    logic [NWRITE*XLEN-1:0] rd_value_in;

    logic [NREAD*XLEN-1:0]  rs_a, rs_b;
    logic                   busy_a, busy_b;

    int errors = 0;
    int checks = 0;
    int cnt;
    int j;

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE),
        .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .reset_in(reset_in), .stall_in(stall_in),
        .rs_in(rs_in), .rs_value_out(rs_a),
        .rd_in(rd_in), .rd_write_in(rd_write_in), .rd_value_in(rd_value_in),
        .clear_in(clear_in), .busy_out(busy_a)
    );

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE),
        .ZERO_REG(1), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .reset_in(reset_in), .stall_in(stall_in),
        .rs_in(rs_in), .rs_value_out(rs_b),
        .rd_in(rd_in), .rd_write_in(rd_write_in), .rd_value_in(rd_value_in),
        .clear_in(clear_in), .busy_out(busy_b)
    );

    function automatic logic [XLEN-1:0] rsa(input int p);
        return rs_a[p*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rsb(input int p);
        return rs_b[p*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int p, input int addr);
        rs_in[p*AW +: AW] = AW'(addr);
    endtask

    task automatic set_wr(input int p, input logic en, input int addr,
                          input logic [XLEN-1:0] data);
        rd_write_in[p]              = en;
        rd_in[p*AW +: AW]           = AW'(addr);
        rd_value_in[p*XLEN +: XLEN] = data;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_in    = 1'b1;
        stall_in    = 1'b0;
        clear_in    = 1'b0;
        rs_in       = '0;
        rd_in       = '0;
        rd_write_in = '0;
        rd_value_in = '0;

        // Reset state
        tick();
        tick();
        check("rst_rs0", rsa(0), 64'h0);
        check("rst_rs1", rsa(1), 64'h0);
        check("rst_busy", 64'(busy_a), 64'h0);
        reset_in = 1'b0;

        // Preload x5/x6 on both ports, read back, then reset wipes them
        set_wr(0, 1'b1, 5, 64'h55);
        set_wr(1, 1'b1, 6, 64'h66);
        tick();
        set_wr(0, 1'b0, 0, 64'h0);
        set_wr(1, 1'b0, 0, 64'h0);
        set_rd(0, 5);
        set_rd(1, 6);
        tick();
        check("pre_x5", rsa(0), 64'h55);
        check("pre_x6", rsb(1), 64'h66);
        reset_in = 1'b1;
        #2;
        check("async_rst_rs0", rsa(0), 64'h0);
        reset_in = 1'b0;
        tick();
        check("post_rst_x5", rsa(0), 64'h0);
        check("post_rst_x6", rsb(1), 64'h0);
        check("post_rst_busy", 64'(busy_a), 64'h0);

        // Same-cycle write/read of x5: bypass vs pre-write value
        set_rd(0, 5);
        set_wr(0, 1'b1, 5, 64'hDEAD_BEEF_0000_0001);
        tick();
        check("byp_x5_a", rsa(0), 64'hDEAD_BEEF_0000_0001);
        check("byp_x5_nb", rsb(0), 64'h0);
        set_wr(0, 1'b0, 0, 64'h0);
        tick();
        check("x5_after_nb", rsb(0), 64'hDEAD_BEEF_0000_0001);

        // Two ports write x7: highest port index wins
        set_wr(0, 1'b1, 7, 64'h11);
        set_wr(1, 1'b1, 7, 64'h22);
        set_rd(1, 7);
        tick();
        check("prio_byp_a", rsa(1), 64'h22);
        check("prio_byp_nb", rsb(1), 64'h0);
        set_wr(0, 1'b0, 0, 64'h0);
        set_wr(1, 1'b0, 0, 64'h0);
        tick();
        check("prio_arr_a", rsa(1), 64'h22);
        check("prio_arr_nb", rsb(1), 64'h22);

        // Distinct addresses commit in the same cycle
        set_wr(0, 1'b1, 10, 64'h10A);
        set_wr(1, 1'b1, 11, 64'h11B);
        tick();
        set_wr(0, 1'b0, 0, 64'h0);
        set_wr(1, 1'b0, 0, 64'h0);
        set_rd(0, 10);
        set_rd(1, 11);
        tick();
        check("dual_x10", rsb(0), 64'h10A);
        check("dual_x11", rsb(1), 64'h11B);

        // x0 is hardwired to zero
        set_wr(0, 1'b1, 0, 64'hFFFF);
        set_rd(0, 0);
        tick();
        check("x0_byp_a", rsa(0), 64'h0);
        check("x0_byp_nb", rsb(0), 64'h0);
        set_wr(0, 1'b0, 0, 64'h0);
        tick();
        check("x0_arr_a", rsa(0), 64'h0);

        // Stall: write to the held address refreshes the held output
        set_wr(0, 1'b1, 3, 64'hAA);
        tick();
        set_wr(0, 1'b0, 0, 64'h0);
        set_rd(0, 3);
        tick();
        check("stall_pre_a", rsa(0), 64'hAA);
        stall_in = 1'b1;
        set_rd(0, 4);
        set_wr(0, 1'b1, 3, 64'hBB);
        tick();
        check("stall_refresh_a", rsa(0), 64'hBB);
        check("stall_hold_nb", rsb(0), 64'hAA);
        set_wr(0, 1'b0, 0, 64'h0);
        tick();
        check("stall_keep_a", rsa(0), 64'hBB);
        check("stall_keep_nb", rsb(0), 64'hAA);
        stall_in = 1'b0;
        set_rd(0, 3);
        tick();
        check("stall_commit_nb", rsb(0), 64'hBB);

        // Stall: write to another address leaves the held output alone
        stall_in = 1'b1;
        set_rd(0, 4);
        set_wr(0, 1'b1, 4, 64'hCC);
        tick();
        check("stall_other_a", rsa(0), 64'hBB);
        check("stall_other_nb", rsb(0), 64'hBB);
        set_wr(0, 1'b0, 0, 64'h0);
        stall_in = 1'b0;
        tick();
        check("unstall_x4_a", rsa(0), 64'hCC);

        // Clear sequence: duration, dropped writes, clear bypass, retrigger ignored
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        cnt = 0;
        j   = 0;
        while (busy_a && (j < 100)) begin
            cnt++;
            if (j == 7) set_rd(1, 7);
            if (j == 8) begin
                check("clr_byp_x7_a", rsa(1), 64'h0);
                check("clr_byp_x7_nb", rsb(1), 64'h22);
            end
            if (j == 10) clear_in = 1'b1;
            if (j == 11) clear_in = 1'b0;
            if (j == 30) begin
                set_wr(0, 1'b1, 9, 64'h99);
                set_rd(0, 9);
            end
            if (j == 31) begin
                check("clr_drop_byp_x9", rsa(0), 64'h0);
                set_wr(0, 1'b0, 0, 64'h0);
            end
            tick();
            j++;
        end
        check("clr_busy_cycles", 64'(cnt), 64'd32);
        check("clr_busy_nb_low", 64'(busy_b), 64'h0);
        tick();
        check("clr_no_retrigger", 64'(busy_a), 64'h0);
        for (int k = 0; k < NREGS / 2; k++) begin
            set_rd(0, 2 * k);
            set_rd(1, 2 * k + 1);
            tick();
            check($sformatf("clr_rd_a_x%0d", 2 * k), rsa(0), 64'h0);
            check($sformatf("clr_rd_a_x%0d", 2 * k + 1), rsa(1), 64'h0);
            check($sformatf("clr_rd_nb_x%0d", 2 * k + 1), rsb(1), 64'h0);
        end

        // Reset asserted mid-clear at idx 5 aborts it and zeroes the array
        set_wr(0, 1'b1, 20, 64'h2020);
        tick();
        set_wr(0, 1'b0, 0, 64'h0);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        repeat (5) tick();
        check("midclr_busy", 64'(busy_a), 64'h1);
        reset_in = 1'b1;
        #1;
        check("midclr_rst_busy", 64'(busy_a), 64'h0);
        reset_in = 1'b0;
        set_rd(0, 20);
        tick();
        check("midclr_x20", rsa(0), 64'h0);
        check("midclr_idle", 64'(busy_a), 64'h0);
        set_wr(1, 1'b1, 20, 64'h77);
        tick();
        set_wr(1, 1'b0, 0, 64'h0);
        tick();
        check("midclr_write_ok", rsb(0), 64'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file, the next generation of the CPU's 2-read/1-write regs block. Generalises width, depth, and read/write port count. Adds:
- write-to-read bypass
- stall-refresh of held operands
- deterministic multi-writer priority
- a sequenced clear engine

Sits between decode (read addresses) and writeback (write ports) in the CPU pipeline.

Parameters:
XLEN, 64, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2)
NREAD, 2, number of read ports
NWRITE, 1, number of write ports
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to read outputs

Ports:
clk  in  1  clock, all state on rising edge
reset_in  in  1  asynchronous active-high reset
stall_in  in  1  hold read outputs
rs_in  in  NREAD*AW  packed read addresses, port r at [r*AW +: AW], AW=$clog2(NREGS)
rs_value_out  out  NREAD*XLEN  packed registered read data
rd_in  in  NWRITE*AW  packed write addresses
rd_write_in  in  NWRITE  per-port write enable
rd_value_in  in  NWRITE*XLEN  packed write data
clear_in  in  1  start sequenced clear (pulse)
busy_out  out  1  clear in progress

Behaviour:
Reset (async, reset_in=1):
- All NREGS entries reset to 0.
- rs_value_out resets to 0.
- busy_out resets to 0.
- FSM goes to IDLE.
- Reset mid-clear aborts the clear immediately.

Effective write:
- Port w is effective iff rd_write_in[w]=1 and busy_out=0.
- It is also blocked when ZERO_REG=1 and its address is 0.
- Effective writes update the array at the clock edge.

Multi-writer priority:
- If several effective ports target the same address, the highest port index wins.
- Writers to distinct addresses all commit in the same cycle.

Read:
- 1-cycle latency: rs_value_out[r] at edge N+1 reflects rs_in[r] sampled at edge N.
- If BYPASS=1 and an effective write targets rs_in[r] in the same cycle, the output takes the winning write data.
- If BYPASS=0, the output takes the pre-write array value.
- ZERO_REG=1 and rs_in[r]=0 gives 0 regardless of any write.

Stall (stall_in=1):
- rs_in is ignored and writes still commit.
- The held output for port r is refreshed only if BYPASS=1 and an effective write targets the address captured at the last non-stalled read (latched per port).
- Otherwise the output is unchanged.

Clear FSM:
- States:
  - IDLE: busy_out=0.
  - CLEAR: busy_out=1, index counter idx is AW bits.
- IDLE -> CLEAR when clear_in=1; idx<=0.
  - Writes in the cycle clear_in is sampled still commit.
  - If they target idx 0, that write is later overwritten by the clear.
- CLEAR:
  - Each cycle entry[idx] <= 0 and idx++.
  - When idx==NREGS-1, return to IDLE next edge.
  - busy_out is high for exactly NREGS cycles.
- In CLEAR, all rd_write_in are dropped and clear_in is ignored.
- Reads operate normally during CLEAR.
  - With BYPASS=1, a read of entry idx in its clear cycle (or a stall-refresh on that address) returns 0.
- idx wraps only via the exit transition and never overflows.

Decomposition:
Package regfile_pkg:
- function clog2-based AW helper
- typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t
- localparam defaults for XLEN/NREGS

Sub-module regfile_wr_select:
- Combinational, per (address query) priority match across NWRITE ports.
- Returns hit and data; used for both array update and bypass.

Test Plan:
- Reset with all entries preloaded via writes -> after reset_in pulse, every read returns 0 and busy_out=0, including when reset asserts mid-clear at idx=5.
- Write x5=0xDEAD_BEEF_0000_0001 while reading x5 same cycle -> BYPASS=1: next-cycle rs_value_out=0xDEAD_BEEF_0000_0001; BYPASS=0: old value 0.
- NWRITE=2, both ports write x7 (port0=0x11, port1=0x22) -> read x7 returns 0x22.
- Write x0=0xFFFF with ZERO_REG=1 -> read x0 returns 0.
- Stall sequence:
  - Read x3 (=0xAA), then assert stall_in and write x3=0xBB -> held output becomes 0xBB.
  - Same sequence writing x4 instead -> output stays 0xAA.
- clear_in with NREGS=32 -> busy_out high exactly 32 cycles.
  - Write to x9 during busy is dropped.
  - After busy_out falls, all reads are 0.
  - A second clear_in during busy has no effect on the duration.
